// File: rtl/blake3_compress_if.sv
// Job/result handshake bundle for the BLAKE3 compression core.
// The slave side is the core; the master side is the block scheduler / comparator.
interface blake3_compress_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] h;
  logic [511:0] m;
  logic [63:0]  counter;
  logic [31:0]  block_len;
  logic [31:0]  flags;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] hash;

  modport slave (
    input  in_valid, h, m, counter, block_len, flags, out_ready,
    output in_ready, out_valid, hash
  );

  modport master (
    output in_valid, h, m, counter, block_len, flags, out_ready,
    input  in_ready, out_valid, hash
  );
endinterface

// File: rtl/blake3_compress.sv
// Iterative BLAKE3 compression core: ROUNDS_PER_CYCLE rounds per clock,
// message permuted alongside the state, feed-forward folded into a registered result.
module blake3_compress #(
  parameter int NUM_ROUNDS       = 7,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit FULL_OUT         = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  blake3_compress_if.slave   io
);

  typedef logic [15:0][31:0] words_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] STEP = 3'(ROUNDS_PER_CYCLE);
  localparam logic [2:0] LAST = 3'(NUM_ROUNDS);

  function automatic words_t g(words_t v, logic [3:0] a, logic [3:0] b,
                               logic [3:0] c, logic [3:0] d,
                               logic [31:0] x, logic [31:0] y);
    logic [31:0] va, vb, vc, vd;
    va = v[a]; vb = v[b]; vc = v[c]; vd = v[d];
    va = va + vb + x;
    vd = vd ^ va;  vd = {vd[15:0], vd[31:16]};
    vc = vc + vd;
    vb = vb ^ vc;  vb = {vb[11:0], vb[31:12]};
    va = va + vb + y;
    vd = vd ^ va;  vd = {vd[7:0], vd[31:8]};
    vc = vc + vd;
    vb = vb ^ vc;  vb = {vb[6:0], vb[31:7]};
    v[a] = va; v[b] = vb; v[c] = vc; v[d] = vd;
    return v;
  endfunction

  function automatic words_t round_fn(words_t v, words_t m);
    v = g(v, 4'd0, 4'd4, 4'd8,  4'd12, m[0],  m[1]);
    v = g(v, 4'd1, 4'd5, 4'd9,  4'd13, m[2],  m[3]);
    v = g(v, 4'd2, 4'd6, 4'd10, 4'd14, m[4],  m[5]);
    v = g(v, 4'd3, 4'd7, 4'd11, 4'd15, m[6],  m[7]);
    v = g(v, 4'd0, 4'd5, 4'd10, 4'd15, m[8],  m[9]);
    v = g(v, 4'd1, 4'd6, 4'd11, 4'd12, m[10], m[11]);
    v = g(v, 4'd2, 4'd7, 4'd8,  4'd13, m[12], m[13]);
    v = g(v, 4'd3, 4'd4, 4'd9,  4'd14, m[14], m[15]);
    return v;
  endfunction

  function automatic words_t permute(words_t m);
    words_t p;
    p[0]  = m[2];  p[1]  = m[6];  p[2]  = m[3];  p[3]  = m[10];
    p[4]  = m[7];  p[5]  = m[0];  p[6]  = m[4];  p[7]  = m[13];
    p[8]  = m[1];  p[9]  = m[11]; p[10] = m[12]; p[11] = m[5];
    p[12] = m[9];  p[13] = m[14]; p[14] = m[15]; p[15] = m[8];
    return p;
  endfunction

  state_t            state;
  words_t            v, m;
  logic [7:0][31:0]  h;
  logic [2:0]        r;
  logic              idle_rdy;
  logic              out_valid;
  logic [511:0]      hash;

  words_t            init_v, v_step, m_step;
  logic [7:0][31:0]  fold_lo, fold_hi;
  logic [2:0]        r_next;

  assign init_v[7:0]  = io.h;
  assign init_v[11:8] = {32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
  assign init_v[12]   = io.counter[31:0];
  assign init_v[13]   = io.counter[63:32];
  assign init_v[14]   = io.block_len;
  assign init_v[15]   = io.flags;

  // NOTE: blocking assignments chain the unrolled rounds inside one combinational
  // block; every output gets its default on the first lines so no latch is inferred.
  always_comb begin
    v_step = v;
    m_step = m;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      v_step = round_fn(v_step, m_step);
      m_step = permute(m_step);
    end
  end

  assign fold_lo = v_step[7:0] ^ v_step[15:8];
  assign fold_hi = FULL_OUT ? (v_step[15:8] ^ h) : '0;
  assign r_next  = r + STEP;

  // In DONE the core can take a new job exactly when the result is being drained.
  assign io.in_ready  = idle_rdy | ((state == DONE) & io.out_ready);
  assign io.out_valid = out_valid;
  assign io.hash      = hash;

  // NOTE: all state uses non-blocking assignments, and the wide state/message
  // registers are reset too so an aborted job leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      v         <= '0;
      m         <= '0;
      h         <= '0;
      r         <= '0;
      idle_rdy  <= 1'b0;
      out_valid <= 1'b0;
      hash      <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (io.in_valid && idle_rdy) begin
            v        <= init_v;
            m        <= io.m;
            h        <= io.h;
            r        <= '0;
            idle_rdy <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          v <= v_step;
          m <= m_step;
          r <= r_next;
          if (r_next == LAST) begin
            hash      <= {fold_hi, fold_lo};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid <= 1'b0;
            if (io.in_valid) begin
              v     <= init_v;
              m     <= io.m;
              h     <= io.h;
              r     <= '0;
              state <= RUN;
            end else begin
              idle_rdy <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake3_compress.sv
// Self-checking bench for blake3_compress: known-answer table, backpressure,
// back-to-back, reset abort and a randomised run against a software reference.
module tb_blake3_compress;

  typedef struct {
    logic [255:0] h;
    logic [511:0] m;
    logic [63:0]  ctr;
    logic [31:0]  bl;
    logic [31:0]  fl;
  } job_t;

  typedef struct {
    job_t         job;
    logic [255:0] exp;
  } vec_t;

  typedef struct {
    logic [511:0] exp;
    int           acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blake3_compress_if ifa ();
  blake3_compress_if ifb ();

  blake3_compress #(.NUM_ROUNDS(7), .ROUNDS_PER_CYCLE(1), .FULL_OUT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .io(ifa)
  );
  blake3_compress #(.NUM_ROUNDS(7), .ROUNDS_PER_CYCLE(7), .FULL_OUT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .io(ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  sb_t q_a[$];
  sb_t q_b[$];

  int GI [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
  int SCHED [7][16] = '{
    '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15},
    '{2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8},
    '{3,4,10,12,13,2,7,14,6,5,9,0,11,15,8,1},
    '{10,7,12,9,14,3,13,15,4,0,11,2,5,8,1,6},
    '{12,13,9,11,15,10,14,8,7,2,5,3,0,1,6,4},
    '{9,14,11,5,8,12,15,1,13,3,0,10,2,6,4,7},
    '{11,15,5,0,1,9,8,6,14,10,2,12,3,4,7,13}};

  function automatic logic [31:0] ror(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Software compress using the precomputed per-round message schedule.
  function automatic logic [511:0] model(job_t j, bit full);
    logic [31:0]  v [16];
    logic [31:0]  w [16];
    logic [31:0]  x, y;
    logic [511:0] o;
    int a, b, c, d;
    for (int k = 0; k < 8; k++)  v[k] = j.h[32*k +: 32];
    for (int k = 0; k < 16; k++) w[k] = j.m[32*k +: 32];
    v[8]  = 32'h6A09E667; v[9]  = 32'hBB67AE85;
    v[10] = 32'h3C6EF372; v[11] = 32'hA54FF53A;
    v[12] = j.ctr[31:0];  v[13] = j.ctr[63:32];
    v[14] = j.bl;         v[15] = j.fl;
    for (int rr = 0; rr < 7; rr++) begin
      for (int gi = 0; gi < 8; gi++) begin
        a = GI[gi][0]; b = GI[gi][1]; c = GI[gi][2]; d = GI[gi][3];
        x = w[SCHED[rr][2*gi]];
        y = w[SCHED[rr][2*gi+1]];
        v[a] = v[a] + v[b] + x;  v[d] = ror(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];      v[b] = ror(v[b] ^ v[c], 12);
        v[a] = v[a] + v[b] + y;  v[d] = ror(v[d] ^ v[a], 8);
        v[c] = v[c] + v[d];      v[b] = ror(v[b] ^ v[c], 7);
      end
    end
    o = '0;
    for (int k = 0; k < 8; k++) begin
      o[32*k +: 32] = v[k] ^ v[k+8];
      if (full) o[32*(k+8) +: 32] = v[k+8] ^ j.h[32*k +: 32];
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: latency at each rise of out_valid, data at each transfer.
  logic prev_va = 1'b0, prev_vb = 1'b0;
  int   rise_a = 0, last_rise_a = 0;
  sb_t  ea, eb;

  always @(negedge clk) begin
    if (ifa.out_valid && !prev_va) begin
      last_rise_a = rise_a;
      rise_a      = cyc;
      if (q_a.size() > 0) check("latency_a", cyc - q_a[0].acc, 7);
    end
    if (ifa.out_valid && ifa.out_ready) begin
      if (q_a.size() == 0) check("spurious_a", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("hash_a", ifa.hash, ea.exp);
      end
    end
    prev_va = ifa.out_valid;
  end

  always @(negedge clk) begin
    if (ifb.out_valid && !prev_vb && q_b.size() > 0)
      check("latency_b", cyc - q_b[0].acc, 1);
    if (ifb.out_valid && ifb.out_ready) begin
      if (q_b.size() == 0) check("spurious_b", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("hash_b", ifb.hash, eb.exp);
      end
    end
    prev_vb = ifb.out_valid;
  end

  task automatic send_a(input job_t j, input logic [511:0] exp, input bit hold);
    sb_t e;
    int  w = 0;
    ifa.h = j.h; ifa.m = j.m; ifa.counter = j.ctr;
    ifa.block_len = j.bl; ifa.flags = j.fl; ifa.in_valid = 1'b1;
    @(negedge clk);
    while (!ifa.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!ifa.in_ready) begin
      check("accept_timeout_a", 0, 1);
      ifa.in_valid = 1'b0;
    end else begin
      e.exp = exp; e.acc = cyc + 1;
      q_a.push_back(e);
      @(posedge clk); #1;
      if (!hold) ifa.in_valid = 1'b0;
    end
  endtask

  task automatic send_b(input job_t j, input logic [511:0] exp);
    sb_t e;
    int  w = 0;
    ifb.h = j.h; ifb.m = j.m; ifb.counter = j.ctr;
    ifb.block_len = j.bl; ifb.flags = j.fl; ifb.in_valid = 1'b1;
    @(negedge clk);
    while (!ifb.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!ifb.in_ready) begin
      check("accept_timeout_b", 0, 1);
    end else begin
      e.exp = exp; e.acc = cyc + 1;
      q_b.push_back(e);
      @(posedge clk); #1;
    end
    ifb.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && w < 100) begin @(posedge clk); w++; end
    check("drain_pending", q_a.size() + q_b.size(), 0);
    q_a.delete(); q_b.delete();
    @(posedge clk); #1;
  endtask

  function automatic job_t rand_job();
    job_t j;
    for (int k = 0; k < 8; k++)  j.h[32*k +: 32] = $urandom();
    for (int k = 0; k < 16; k++) j.m[32*k +: 32] = $urandom();
    j.ctr = {$urandom(), $urandom()};
    j.bl  = $urandom_range(0, 64);
    j.fl  = $urandom_range(0, 15);
    return j;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t         tbl [5];
  job_t         kat, j1, j2;
  logic [511:0] full, held;
  int           w, seen;

  initial begin
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
    ifa.h = '0; ifa.m = '0; ifa.counter = '0; ifa.block_len = '0; ifa.flags = '0;
    ifb.h = '0; ifb.m = '0; ifb.counter = '0; ifb.block_len = '0; ifb.flags = '0;

    kat.h   = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
               32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
    kat.m   = '0; kat.ctr = '0; kat.bl = '0; kat.fl = 32'h0B;
    tbl[0].job = kat;
    tbl[0].exp = {32'h62321FE4, 32'hCA939ACC, 32'hB712C1AD, 32'hC925CB9B,
                  32'h49C9DC36, 32'hEA4D40A0, 32'hA6A1F9F5, 32'hB94913AF};
    tbl[1].job = '{h: '1, m: '1, ctr: '1, bl: '1, fl: '1};
    tbl[2].job = '{h: kat.h, m: '0, ctr: 64'h0000_0000_FFFF_FFFF, bl: 32'd64, fl: 32'h1};
    tbl[3].job = '{h: '0, m: '0, ctr: 64'h1_0000_0000, bl: 32'd0, fl: 32'h0};
    tbl[4].job = rand_job();
    for (int k = 0; k < 16; k++) tbl[3].job.m[32*k +: 32] = 32'h0101_0101 * k;
    for (int i = 1; i < 5; i++) begin
      full = model(tbl[i].job, 1'b0);
      tbl[i].exp = full[255:0];
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready_a", ifa.in_ready, 0);
    check("rst_out_valid_a", ifa.out_valid, 0);
    check("rst_hash_a", ifa.hash, 0);
    check("rst_in_ready_b", ifb.in_ready, 0);
    check("rst_hash_b", ifb.hash, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_edge", ifa.in_ready, 0);
    @(posedge clk); #1;
    check("ready_after_first_edge", ifa.in_ready, 1);

    // Known-answer and patterned table on the one-round-per-cycle core.
    for (int i = 0; i < 5; i++) begin
      send_a(tbl[i].job, {256'b0, tbl[i].exp}, 1'b0);
      drain();
    end

    // Same known answer on the fully unrolled core, upper words from the model.
    full = model(kat, 1'b1);
    send_b(kat, {full[511:256], tbl[0].exp});
    drain();

    // Backpressure: result held for 5 cycles, then exactly one transfer.
    ifa.out_ready = 1'b0;
    send_a(tbl[1].job, {256'b0, tbl[1].exp}, 1'b0);
    w = 0;
    @(negedge clk);
    while (!ifa.out_valid && w < 20) begin @(negedge clk); w++; end
    check("bp_valid_rise", ifa.out_valid, 1);
    held = ifa.hash;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", ifa.out_valid, 1);
      check("bp_hash_stable", ifa.hash, held);
      check("bp_in_ready_low", ifa.in_ready, 0);
    end
    @(posedge clk); #1 ifa.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_one_transfer", q_a.size(), 0);
    check("bp_valid_drop", ifa.out_valid, 0);
    drain();

    // Back-to-back with in_valid held: results 8 cycles apart.
    j1 = rand_job(); j2 = rand_job();
    send_a(j1, model(j1, 1'b0), 1'b1);
    send_a(j2, model(j2, 1'b0), 1'b0);
    drain();
    check("b2b_spacing", rise_a - last_rise_a, 8);

    // Reset at round 3: outputs clear at once, result never appears.
    j1 = rand_job();
    send_a(j1, model(j1, 1'b0), 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", ifa.out_valid, 0);
    check("rst_mid_hash", ifa.hash, 0);
    check("rst_mid_in_ready", ifa.in_ready, 0);
    q_a.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    check("rst_no_result", seen, 0);
    check("rst_hash_still_zero", ifa.hash, 0);
    @(posedge clk); #1;
    j2 = rand_job();
    send_a(j2, model(j2, 1'b0), 1'b0);
    drain();

    // Randomised jobs: a few on the iterative core, 1000 on the full-output core.
    for (int i = 0; i < 40; i++) begin
      j1 = rand_job();
      send_a(j1, model(j1, 1'b0), 1'b0);
    end
    drain();
    for (int i = 0; i < 1000; i++) begin
      j1 = rand_job();
      send_b(j1, model(j1, 1'b1));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
